// File: rtl/execute_stage.sv
// EX stage: forwarding muxes, ALU, branch/jump resolution and the EX/MEM pipeline register.
// Optional performance counters are built when EXEC_PERF_CNT_EN is defined.
module execute_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [XLEN-1:0]  RD1E,
   input  logic [XLEN-1:0]  RD2E,
   input  logic [XLEN-1:0]  PCE,
   input  logic [XLEN-1:0]  ImmExtE,
   input  logic [XLEN-1:0]  PCPlus4E,
   input  logic [4:0]       RdE,
   input  logic [10:0]      controlE,
   input  logic [2:0]       funct3E,
   input  logic [1:0]       ForwardAE,
   input  logic [1:0]       ForwardBE,
   input  logic [XLEN-1:0]  ResultW,
   output logic             PCSrcE,
   output logic [XLEN-1:0]  PCTargetE,
   output logic [XLEN-1:0]  ALUResultM,
   output logic [XLEN-1:0]  WriteDataM,
   output logic [XLEN-1:0]  PCPlus4M,
   output logic [4:0]       RdM,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic [1:0]       ResultSrcM,
   output logic [2:0]       funct3M,
   output logic [CNT_W-1:0] InstrCntE,
   output logic [CNT_W-1:0] BrTakenCntE
);

   logic            w_regwrite, w_memwrite, w_jump, w_branch, w_alusrc, w_cond;
   logic [1:0]      w_resultsrc;
   logic [3:0]      w_aluctl;
   logic [XLEN-1:0] w_srca, w_fwdb, w_srcb, w_aluout;

   logic            r_regwrite, r_memwrite;
   logic [1:0]      r_resultsrc;
   logic [2:0]      r_funct3;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_aluresult, r_writedata, r_pcplus4;

   function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rd,
                                               input logic [XLEN-1:0] resw, input logic [XLEN-1:0] alum);
      case (sel)
         2'b01:   return resw;
         2'b10:   return alum;
         default: return rd;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      logic [4:0]             sh;
      sa = a;
      sb = b;
      sh = b[4:0];
      case (op)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return a & b;
         4'b0011: return a | b;
         4'b0100: return a ^ b;
         4'b0101: return {{(XLEN-1){1'b0}}, (sa < sb)};
         4'b0110: return {{(XLEN-1){1'b0}}, (a < b)};
         4'b0111: return a << sh;
         4'b1000: return a >> sh;
         4'b1001: return $unsigned(sa >>> sh);
         4'b1010: return b;
         default: return '0;
      endcase
   endfunction

   // Branch compares the forwarded rs2 value, never the immediate.
   function automatic logic br_cond(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      sa = a;
      sb = b;
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return sa < sb;
         3'b101:  return sa >= sb;
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   assign {w_regwrite, w_resultsrc, w_memwrite, w_jump, w_branch, w_aluctl, w_alusrc} = controlE;

   assign w_srca    = fwd_mux(ForwardAE, RD1E, ResultW, r_aluresult);
   assign w_fwdb    = fwd_mux(ForwardBE, RD2E, ResultW, r_aluresult);
   assign w_srcb    = w_alusrc ? ImmExtE : w_fwdb;
   assign w_aluout  = alu(w_aluctl, w_srca, w_srcb);
   assign w_cond    = br_cond(funct3E, w_srca, w_fwdb);
   assign PCSrcE    = w_jump | (w_branch & w_cond);
   assign PCTargetE = PCE + ImmExtE;

   // EX -> MEM boundary
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_aluresult <= '0;
         r_writedata <= '0;
         r_pcplus4   <= '0;
         r_rd        <= '0;
         r_regwrite  <= 1'b0;
         r_memwrite  <= 1'b0;
         r_resultsrc <= '0;
         r_funct3    <= '0;
      end else begin
         r_aluresult <= w_aluout;
         r_writedata <= w_fwdb;
         r_pcplus4   <= PCPlus4E;
         r_rd        <= RdE;
         r_regwrite  <= w_regwrite;
         r_memwrite  <= w_memwrite;
         r_resultsrc <= w_resultsrc;
         r_funct3    <= funct3E;
      end
   end

   assign ALUResultM = r_aluresult;
   assign WriteDataM = r_writedata;
   assign PCPlus4M   = r_pcplus4;
   assign RdM        = r_rd;
   assign RegWriteM  = r_regwrite;
   assign MemWriteM  = r_memwrite;
   assign ResultSrcM = r_resultsrc;
   assign funct3M    = r_funct3;

`ifdef EXEC_PERF_CNT_EN
   logic [CNT_W-1:0] r_instr_cnt, r_br_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_instr_cnt <= '0;
         r_br_cnt    <= '0;
      end else begin
         if (controlE != '0) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
         if (PCSrcE)         r_br_cnt    <= r_br_cnt + CNT_W'(1);
      end
   end

   assign InstrCntE   = r_instr_cnt;
   assign BrTakenCntE = r_br_cnt;
`else
   assign InstrCntE   = '0;
   assign BrTakenCntE = '0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: vector table, hand-written sequences and randomized
// stimulus against an arithmetic reference model.
module tb_execute_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
   logic [4:0]  RdE;
   logic [10:0] controlE;
   logic [2:0]  funct3E;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        PCSrcE;
   logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  funct3M;
   logic [31:0] InstrCntE, BrTakenCntE;

`ifdef EXEC_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   execute_stage #(.XLEN(32), .CNT_W(32)) dut (
      .CLK(CLK), .RST(RST), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
      .PCPlus4E(PCPlus4E), .RdE(RdE), .controlE(controlE), .funct3E(funct3E),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM),
      .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M),
      .InstrCntE(InstrCntE), .BrTakenCntE(BrTakenCntE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] rd1, rd2, pc, imm, rw;
      logic [4:0]  rd;
      logic [10:0] ctl;
      logic [2:0]  f3;
      logic [1:0]  fa, fb;
      logic        exp_pcsrc;
      logic [31:0] exp_alu;
   } vec_t;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] m_alum = 0;
   int          m_instr = 0;
   int          m_br = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] mk(input bit rw, input logic [1:0] rs, input bit mw, input bit j,
                                      input bit b, input logic [3:0] op, input bit src);
      return {rw, rs, mw, j, b, op, src};
   endfunction

   function automatic vec_t mkv(input logic [31:0] rd1, rd2, pc, imm, rw, input logic [10:0] ctl,
                                input logic [2:0] f3, input logic [1:0] fa, fb,
                                input logic pcs, input logic [31:0] alu);
      vec_t v;
      v.rd1 = rd1; v.rd2 = rd2; v.pc = pc; v.imm = imm; v.rw = rw; v.rd = rd1[4:0] ^ 5'd9;
      v.ctl = ctl; v.f3 = f3; v.fa = fa; v.fb = fb; v.exp_pcsrc = pcs; v.exp_alu = alu;
      return v;
   endfunction

   function automatic logic [31:0] fwd_ref(input logic [1:0] s, input logic [31:0] rd, rw, alum);
      if (s == 2'd1) return rw;
      if (s == 2'd2) return alum;
      return rd;
   endfunction

   // Reference ALU in plain integer arithmetic.
   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b);
      longint ua, ub, sa, d, q;
      int     sh;
      ua = longint'(a); ub = longint'(b); sa = longint'($signed(a));
      sh = int'(b % 32);
      d  = longint'(1) << sh;
      case (op)
         4'd0: return 32'(ua + ub);
         4'd1: return 32'(ua - ub);
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
         4'd6: return (ua < ub) ? 32'd1 : 32'd0;
         4'd7: return 32'(ua * d);
         4'd8: return 32'(ua / d);
         4'd9: begin
            q = sa / d;
            if (sa < 0 && (sa % d) != 0) q = q - 1;
            return 32'(q);
         end
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic taken_ref(input logic [10:0] ctl, input logic [2:0] f3, input logic [31:0] a, b);
      longint sa, sb;
      logic   c;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      case (f3)
         3'd0: c = (a == b);
         3'd1: c = (a != b);
         3'd4: c = (sa < sb);
         3'd5: c = (sa >= sb);
         3'd6: c = (a < b);
         3'd7: c = (a >= b);
         default: c = 1'b0;
      endcase
      return ctl[6] | (ctl[5] & c);
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_alu"}, ALUResultM, 0);
      check({tag, "_wd"}, WriteDataM, 0);
      check({tag, "_pc4"}, PCPlus4M, 0);
      check({tag, "_rd"}, 32'(RdM), 0);
      check({tag, "_ctl"}, {27'd0, RegWriteM, MemWriteM, ResultSrcM, 1'b0}, 0);
      check({tag, "_f3"}, 32'(funct3M), 0);
      check({tag, "_icnt"}, InstrCntE, 0);
      check({tag, "_bcnt"}, BrTakenCntE, 0);
   endtask

   // Drive one instruction at posedge+1, check combinational outputs, then the M stage after the edge.
   task automatic run(input vec_t v, input bit rst, input string tag);
      logic [31:0] exp_wd;
      RST = rst; RD1E = v.rd1; RD2E = v.rd2; PCE = v.pc; ImmExtE = v.imm;
      PCPlus4E = v.pc + 32'd4; ResultW = v.rw; RdE = v.rd; controlE = v.ctl;
      funct3E = v.f3; ForwardAE = v.fa; ForwardBE = v.fb;
      exp_wd = fwd_ref(v.fb, v.rd2, v.rw, m_alum);
      #2;
      check({tag, "_pcsrc"}, 32'(PCSrcE), 32'(v.exp_pcsrc));
      check({tag, "_target"}, PCTargetE, 32'(longint'(v.pc) + longint'(v.imm)));
      @(posedge CLK); #1;
      if (rst) begin
         m_alum = 0; m_instr = 0; m_br = 0;
         check_zero(tag);
      end else begin
         m_alum = v.exp_alu;
         if (v.ctl != 0) m_instr++;
         if (v.exp_pcsrc) m_br++;
         check({tag, "_alu"}, ALUResultM, v.exp_alu);
         check({tag, "_wd"}, WriteDataM, exp_wd);
         check({tag, "_pc4"}, PCPlus4M, v.pc + 32'd4);
         check({tag, "_rd"}, 32'(RdM), 32'(v.rd));
         check({tag, "_rw"}, 32'(RegWriteM), 32'(v.ctl[10]));
         check({tag, "_mw"}, 32'(MemWriteM), 32'(v.ctl[7]));
         check({tag, "_rs"}, 32'(ResultSrcM), 32'(v.ctl[9:8]));
         check({tag, "_f3"}, 32'(funct3M), 32'(v.f3));
         check({tag, "_icnt"}, InstrCntE, PERF ? 32'(m_instr) : 32'd0);
         check({tag, "_bcnt"}, BrTakenCntE, PERF ? 32'(m_br) : 32'd0);
      end
      RST = 1'b0;
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v;
      logic [31:0] a, b, sb;

      RST = 1'b1; RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0; ResultW = 0;
      RdE = 0; controlE = 0; funct3E = 0; ForwardAE = 0; ForwardBE = 0;
      repeat (2) @(posedge CLK);
      #1;
      check_zero("reset");
      RST = 1'b0;

      tbl.push_back(mkv(5, 7, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'b0001, 0), 0, 0, 0, 0, 32'hFFFFFFFE));
      tbl.push_back(mkv(32'h80000000, 0, 0, 4, 0, mk(1, 0, 0, 0, 0, 4'b1001, 1), 0, 0, 0, 0, 32'hF8000000));
      tbl.push_back(mkv(32'h80000000, 4, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'b1000, 0), 0, 0, 0, 0, 32'h08000000));
      tbl.push_back(mkv(32'hFFFFFFFF, 1, 100, 32'hFFFFFFF8, 0, mk(0, 0, 0, 0, 1, 4'b0000, 0), 3'b100, 0, 0, 1, 0));
      tbl.push_back(mkv(32'hFFFFFFFF, 1, 100, 32'hFFFFFFF8, 0, mk(0, 0, 0, 0, 1, 4'b0000, 0), 3'b110, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 2, 32'h1000, 32'h12345000, 0, mk(1, 2'b10, 0, 1, 1, 4'b1010, 1), 3'b010, 0, 0, 1, 32'h12345000));
      tbl.push_back(mkv(32'hFFFFFFFF, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'b0101, 0), 0, 0, 0, 0, 1));
      tbl.push_back(mkv(32'hFFFFFFFF, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'b0110, 0), 0, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 33, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'b0111, 0), 0, 0, 0, 0, 2));
      tbl.push_back(mkv(3, 4, 0, 0, 0, mk(1, 0, 1, 0, 0, 4'b1111, 0), 3'b010, 0, 0, 0, 0));
      tbl.push_back(mkv(32'h99, 3, 0, 0, 32'h10, mk(1, 1, 0, 0, 0, 4'b0000, 0), 0, 2'b01, 2'b11, 0, 32'h13));
      tbl.push_back(mkv(7, 8, 0, 0, 0, 11'd0, 0, 0, 0, 0, 15));
      tbl.push_back(mkv(5, 5, 8, 16, 0, mk(0, 0, 1, 0, 1, 4'b0100, 0), 3'b000, 0, 0, 1, 0));
      foreach (tbl[i]) run(tbl[i], 1'b0, $sformatf("vec%0d", i));

      // Forward from M: previous result 42 plus ResultW 8.
      run(mkv(40, 2, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 42), 1'b0, "fwd_a");
      run(mkv(1000, 2000, 0, 0, 8, mk(1, 0, 0, 0, 0, 4'b0000, 0), 0, 2'b10, 2'b01, 0, 50), 1'b0, "fwd_b");

      // Reset coinciding with a taken branch: redirect still asserts, M stage clears.
      run(mkv(5, 5, 64, 8, 0, mk(1, 0, 1, 0, 1, 4'b0000, 0), 3'b000, 0, 0, 1, 10), 1'b1, "rst_br");

      // Counter sequence: 3 valid, 1 bubble, 1 JAL.
      run(mkv(0, 0, 0, 0, 0, 11'd0, 0, 0, 0, 0, 0), 1'b1, "cnt_rst");
      for (int i = 0; i < 3; i++)
         run(mkv(i, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, i + 1), 1'b0, "cnt_v");
      run(mkv(2, 2, 0, 0, 0, 11'd0, 0, 0, 0, 0, 4), 1'b0, "cnt_bub");
      run(mkv(0, 0, 32'h200, 32'h40, 0, mk(1, 2'b10, 0, 1, 0, 4'b0000, 0), 0, 0, 0, 1, 0), 1'b0, "cnt_jal");
      check("cnt_instr_total", InstrCntE, PERF ? 32'd4 : 32'd0);
      check("cnt_br_total", BrTakenCntE, PERF ? 32'd1 : 32'd0);

      for (int i = 0; i < 300; i++) begin
         v.rd1 = $urandom;
         v.rd2 = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
         if ($urandom_range(0, 3) == 0) v.rd2 = 32'($urandom_range(0, 40));
         v.pc  = $urandom; v.imm = $urandom; v.rw = $urandom; v.rd = 5'($urandom);
         v.ctl = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
         v.f3  = 3'($urandom); v.fa = 2'($urandom); v.fb = 2'($urandom);
         a  = fwd_ref(v.fa, v.rd1, v.rw, m_alum);
         b  = fwd_ref(v.fb, v.rd2, v.rw, m_alum);
         sb = v.ctl[0] ? v.imm : b;
         v.exp_alu   = alu_ref(v.ctl[4:1], a, sb);
         v.exp_pcsrc = taken_ref(v.ctl, v.f3, a, b);
         run(v, ($urandom_range(0, 49) == 0), $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
